// File: rtl/mem_port_ctrl.sv
// CPU-to-memory port controller: single outstanding word access
// with alignment check, wait timeout and one-cycle completion pulse.
module mem_port_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        Rst,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        cpu_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      next;
  logic [7:0]  cnt;
  logic [29:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [31:0] rdata_q;

  logic one_req;
  logic aligned;
  logic timed_out;

  assign one_req   = cpu_rd ^ cpu_wr;
  assign aligned   = (cpu_addr[1:0] == 2'b00);
  assign timed_out = !mem_ack && (cnt == LAST);

  // State register, request latch, wait counter and read data capture
  always_ff @(posedge CLK) begin
    if (Rst) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      addr_q  <= 30'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state <= next;
      case (state)
        IDLE: begin
          cnt <= 8'd0;
          if (one_req && aligned) begin
            addr_q  <= cpu_addr[31:2];
            wdata_q <= cpu_wdata;
            we_q    <= cpu_wr;
          end
        end
        REQ: begin
          if (mem_ack) begin
            if (!we_q)
              rdata_q <= mem_rdata;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state decode and state-only output decode
  always_comb begin
    next      = state;
    cpu_ready = 1'b0;
    cpu_err   = 1'b0;
    mem_req   = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_rd && cpu_wr)
          next = ERR;
        else if (one_req)
          next = aligned ? REQ : ERR;
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_ack)
          next = DONE;
        else if (timed_out)
          next = ERR;
      end
      DONE: begin
        cpu_ready = 1'b1;
        next      = IDLE;
      end
      ERR: begin
        cpu_ready = 1'b1;
        cpu_err   = 1'b1;
        next      = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  assign cpu_rdata = rdata_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Bench for mem_port_ctrl: directed and random transactions checked
// against a transaction-level model of the expected bus behaviour.
module tb_mem_port_ctrl;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        Rst;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_err;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] m_rdata;

  mem_port_ctrl #(.TIMEOUT(TO)) dut (
    .CLK(CLK),
    .Rst(Rst),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rd(cpu_rd),
    .cpu_wr(cpu_wr),
    .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready),
    .cpu_err(cpu_err),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %h, exp %h", tag, got, exp);
    end
  endtask

  // One CPU transaction. ack_at: REQ cycle (1-based) carrying mem_ack,
  // 0 or beyond TO means memory never answers in time.
  task automatic txn(input bit rd, input bit wr,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int ack_at, input logic [31:0] rv);
    bit bad;
    bit acked;
    int c;
    bad = (rd && wr) || (a[1:0] != 2'b00);
    cpu_rd    = rd;
    cpu_wr    = wr;
    cpu_addr  = a;
    cpu_wdata = wd;
    step;
    if (bad) begin
      chk("bad_mreq", 32'(mem_req), 0);
      chk("bad_rdy", 32'(cpu_ready), 1);
      chk("bad_err", 32'(cpu_err), 1);
      chk("bad_rdata", cpu_rdata, m_rdata);
    end else begin
      c = 0;
      acked = 0;
      while (!acked && c < TO) begin
        c++;
        chk("req_mreq", 32'(mem_req), 1);
        chk("req_we", 32'(mem_we), 32'(wr));
        chk("req_addr", 32'(mem_addr), 32'(a[31:2]));
        chk("req_wdata", mem_wdata, wd);
        chk("req_rdy", 32'(cpu_ready), 0);
        cpu_addr  = $urandom;
        cpu_wdata = $urandom;
        if (c == ack_at) begin
          mem_ack   = 1'b1;
          mem_rdata = rv;
          acked     = 1;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = $urandom;
        end
        step;
      end
      mem_ack = 1'b0;
      chk("end_mreq", 32'(mem_req), 0);
      chk("end_rdy", 32'(cpu_ready), 1);
      chk("end_err", 32'(cpu_err), 32'(!acked));
      if (acked && rd)
        m_rdata = rv;
      chk("end_rdata", cpu_rdata, m_rdata);
    end
    cpu_rd    = 1'b0;
    cpu_wr    = 1'b0;
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    step;
    chk("idle_rdy", 32'(cpu_ready), 0);
    chk("idle_mreq", 32'(mem_req), 0);
    step;
    chk("idle2_rdy", 32'(cpu_ready), 0);
    chk("idle2_rdata", cpu_rdata, m_rdata);
    mem_ack = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] a;
    int kind;
    bit rd;
    bit wr;
    Rst       = 1'b1;
    cpu_addr  = 32'd0;
    cpu_wdata = 32'd0;
    cpu_rd    = 1'b0;
    cpu_wr    = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    m_rdata   = 32'd0;
    step;
    step;
    chk("rst_rdy", 32'(cpu_ready), 0);
    chk("rst_err", 32'(cpu_err), 0);
    chk("rst_mreq", 32'(mem_req), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", cpu_rdata, 0);
    Rst = 1'b0;
    step;

    txn(1, 0, 32'h0000_0010, 32'hA5A5_A5A5, 3, 32'h8C01_0004);
    txn(0, 1, 32'h0000_0020, 32'h1234_5678, 1, 32'hFFFF_0000);
    txn(1, 0, 32'h0000_0003, 32'h0, 1, 32'h1111_1111);
    txn(1, 0, 32'h0000_0100, 32'h0, 0, 32'h2222_2222);
    txn(1, 0, 32'h0000_0104, 32'h0, TO, 32'h3333_3333);
    txn(0, 1, 32'h0000_0108, 32'h4444_4444, TO, 32'h0);
    txn(1, 1, 32'h0000_0008, 32'h5555_5555, 1, 32'h6666_6666);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      r = $urandom;
      a = {r[31:2], 2'b00};
      rd = 1'($urandom_range(0, 1));
      wr = !rd;
      if (kind == 0) begin
        rd = 1;
        wr = 1;
      end else if (kind == 1) begin
        a[1:0] = 2'($urandom_range(1, 3));
      end
      txn(rd, wr, a, $urandom, $urandom_range(0, TO + 1), $urandom);
    end

    cpu_rd   = 1'b1;
    cpu_addr = 32'h0000_0040;
    step;
    chk("rm_req1", 32'(mem_req), 1);
    step;
    chk("rm_req2", 32'(mem_req), 1);
    Rst       = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    step;
    Rst    = 1'b0;
    cpu_rd = 1'b0;
    m_rdata = 32'd0;
    chk("rm_mreq", 32'(mem_req), 0);
    chk("rm_rdy", 32'(cpu_ready), 0);
    chk("rm_rdata", cpu_rdata, m_rdata);
    step;
    chk("rm_late_mreq", 32'(mem_req), 0);
    chk("rm_late_rdy", 32'(cpu_ready), 0);
    chk("rm_late_rdata", cpu_rdata, m_rdata);
    mem_ack = 1'b0;
    step;
    chk("rm_idle_rdy", 32'(cpu_ready), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
